spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//  Register bank on the internal bus, directly downstream of the SPI command decoder.
//  Commits SPI writes (spi_req/spi_ack handshake) and returns read data on reg_dout.
//  Exports 8 control registers to the switch core and imports 16 status words from it.
//  Provides a W1C interrupt register with mask and an irq output.
// PARAMETERS
//  CTRL_RST   16'h0000  reset value of CTRL0..CTRL7
//  ID_VAL     16'h5A01  constant returned at address 0x0F
// PORTS
//  clk        in   1    system clock; all logic rising-edge
//  rst        in   1    synchronous reset, active-high
//  spi_req    in   1    write request; level, held until spi_ack seen
//  spi_ack    out  1    write acknowledge, 1-cycle pulse
//  spi_addr   in   7    register address; 0x00-0x7F
//  reg_din    in   16   write data; valid while spi_req=1
//  reg_dout   out  16   read data for spi_addr, registered
//  ctrl_regs  out  128  CTRLn at [16n+15:16n], n=0..7
//  ctrl_wr    out  8    one-hot pulse: CTRLn written this cycle
//  sts_in     in   256  status word k at [16k+15:16k], k=0..15
//  irq_set    in   16   per-bit 1-cycle set pulses into IRQ_STAT
//  irq        out  1    registered |(IRQ_STAT & IRQ_MASK)
// BEHAVIOUR
//  Map:
//   0x00-07  CTRL0-7, RW
//   0x08     IRQ_STAT, W1C
//   0x09     IRQ_MASK, RW
//   0x0A     SCRATCH, RW
//   0x0F     ID, RO
//   0x10-1F  STS0-15, RO; live view of sts_in
//   Other addresses read 16'h0000.
//  Reads: each clk, reg_dout <= mux(spi_addr), so reg_dout reflects spi_addr one cycle earlier.
//   A write is visible on reg_dout 2 cycles after commit when spi_addr is held.
//  Write FSM: IDLE, ACK, HOLD.
//   IDLE: spi_req=1 -> commit reg_din to spi_addr in this cycle, go ACK.
//   ACK: spi_ack=1 for exactly this cycle, go HOLD.
//   HOLD: wait for spi_req=0, then IDLE. No second commit while spi_req stays high.
//  Every request is acked once: writes to RO addresses, ID and unmapped addresses are
//   discarded but acked normally. Ack latency is 1 cycle after req is first sampled.
//  ctrl_wr[n] pulses in the ACK cycle; ctrl_regs already holds the new value in that cycle.
//  IRQ_STAT next = (STAT & ~w1c_mask) | irq_set.
//   w1c_mask = reg_din only on a commit to 0x08, else 0.
//   A set pulse and a W1C on the same bit in the same cycle leave the bit at 1.
//  irq updates 1 cycle after STAT or MASK changes.
//  Reset (any cycle, including mid-handshake): FSM=IDLE, spi_ack=0, ctrl_wr=0, irq=0,
//   reg_dout=0, CTRLn=CTRL_RST, IRQ_STAT=0, IRQ_MASK=0, SCRATCH=0.
//   A request still high after reset is treated as a new request.
//  spi_addr[6:5]!=0 is unmapped; there is no address aliasing.
// TESTING
//  T1 reset: hold rst=1 for 3 cycles -> all outputs 0, ctrl_regs = 8 copies of CTRL_RST;
//     addr 0x0F reads 16'h5A01.
//  T2 write: req, addr=0x03, din=16'hBEEF -> ack 1 cycle later, ctrl_wr=8'h08 in that cycle,
//     ctrl_regs[63:48]=BEEF; read of 0x03 returns BEEF.
//  T3 held req: spi_req high for 10 cycles -> exactly one spi_ack and one commit;
//     a new req after a low gap is acked again.
//  T4 RO/unmapped: write 16'h1234 to 0x0F, 0x15 and 0x40 -> each acked; reads return
//     5A01, sts_in word 5 and 0000.
//  T5 IRQ: MASK=0x0001, irq_set[0] pulse -> STAT=0x0001 and irq=1 one cycle later;
//     W1C 0x0001 together with a new irq_set[0] pulse -> bit stays 1;
//     W1C alone -> STAT=0, irq=0.
//  T6 mid-handshake reset: rst asserted in ACK cycle -> spi_ack=0 next cycle, state IDLE;
//     req still high after reset -> re-acked once.

Source files
------------

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI command decoder: write handshake FSM, control/status map,
// W1C interrupt status with mask, registered read mux.
module spi_reg_bank #(
  parameter logic [15:0] CTRL_RST = 16'h0000,
  parameter logic [15:0] ID_VAL   = 16'h5A01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spi_req,
  output logic         spi_ack,
  input  logic [6:0]   spi_addr,
  input  logic [15:0]  reg_din,
  output logic [15:0]  reg_dout,
  output logic [127:0] ctrl_regs,
  output logic [7:0]   ctrl_wr,
  input  logic [255:0] sts_in,
  input  logic [15:0]  irq_set,
  output logic         irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_HOLD
  } state_t;

  state_t      state_reg, state_next;
  logic        commit;
  logic [7:0]  ctrl_sel;
  logic [7:0]  ctrl_wr_reg;
  logic [15:0] irq_stat_reg, irq_stat_next;
  logic [15:0] irq_mask_reg;
  logic [15:0] scratch_reg;
  logic [15:0] w1c_mask;
  logic        irq_reg;
  logic [15:0] rd_data;
  logic [15:0] reg_dout_reg;

  // ---------------- write handshake FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The only commit point is IDLE with a request, so a held request cannot write twice.
  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (spi_req) begin
          commit     = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_HOLD;
      ST_HOLD: begin
        if (!spi_req) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign spi_ack = (state_reg == ST_ACK);

  // ---------------- control registers ----------------
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : gen_ctrl
      logic [15:0] val_reg;

      assign ctrl_sel[gi] = commit && (spi_addr == 7'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          val_reg <= CTRL_RST;
        end else if (ctrl_sel[gi]) begin
          val_reg <= reg_din;
        end
      end

      assign ctrl_regs[16*gi +: 16] = val_reg;
    end
  endgenerate

  // Strobe is registered from the commit, so it lands in the ACK cycle with the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_wr_reg <= 8'h00;
    end else begin
      ctrl_wr_reg <= ctrl_sel;
    end
  end

  assign ctrl_wr = ctrl_wr_reg;

  // ---------------- interrupt, mask, scratch ----------------
  assign w1c_mask = (commit && (spi_addr == 7'h08)) ? reg_din : 16'h0000;

  // Set wins over clear on the same bit.
  assign irq_stat_next = (irq_stat_reg & ~w1c_mask) | irq_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_stat_reg <= 16'h0000;
      irq_mask_reg <= 16'h0000;
      scratch_reg  <= 16'h0000;
      irq_reg      <= 1'b0;
    end else begin
      irq_stat_reg <= irq_stat_next;
      if (commit && (spi_addr == 7'h09)) begin
        irq_mask_reg <= reg_din;
      end
      if (commit && (spi_addr == 7'h0A)) begin
        scratch_reg <= reg_din;
      end
      irq_reg <= |(irq_stat_reg & irq_mask_reg);
    end
  end

  assign irq = irq_reg;

  // ---------------- read path ----------------
  always_comb begin
    rd_data = 16'h0000;
    if (spi_addr[6:5] == 2'b00) begin
      if (spi_addr[4]) begin
        rd_data = sts_in[16*spi_addr[3:0] +: 16];
      end else begin
        case (spi_addr[3:0])
          4'h0, 4'h1, 4'h2, 4'h3,
          4'h4, 4'h5, 4'h6, 4'h7: rd_data = ctrl_regs[16*spi_addr[2:0] +: 16];
          4'h8:                   rd_data = irq_stat_reg;
          4'h9:                   rd_data = irq_mask_reg;
          4'hA:                   rd_data = scratch_reg;
          4'hF:                   rd_data = ID_VAL;
          default:                rd_data = 16'h0000;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_dout_reg <= 16'h0000;
    end else begin
      reg_dout_reg <= rd_data;
    end
  end

  assign reg_dout = reg_dout_reg;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: stimulus pushes expectations into queues, a negedge
// monitor pops them when the DUT acks or when a probe point is flagged.
module tb_spi_reg_bank;

  localparam logic [15:0] CTRL_RST = 16'h0000;
  localparam logic [15:0] ID_VAL   = 16'h5A01;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         spi_req = 1'b0;
  logic         spi_ack;
  logic [6:0]   spi_addr = 7'h00;
  logic [15:0]  reg_din = 16'h0000;
  logic [15:0]  reg_dout;
  logic [127:0] ctrl_regs;
  logic [7:0]   ctrl_wr;
  logic [255:0] sts_in = '0;
  logic [15:0]  irq_set = 16'h0000;
  logic         irq;

  spi_reg_bank #(.CTRL_RST(CTRL_RST), .ID_VAL(ID_VAL)) dut (
    .clk(clk), .rst(rst), .spi_req(spi_req), .spi_ack(spi_ack), .spi_addr(spi_addr),
    .reg_din(reg_din), .reg_dout(reg_dout), .ctrl_regs(ctrl_regs), .ctrl_wr(ctrl_wr),
    .sts_in(sts_in), .irq_set(irq_set), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   cw;
    logic [127:0] regs;
  } ack_t;

  typedef struct {
    string        name;
    int           sel;
    logic [127:0] val;
  } obs_t;

  ack_t         ack_q[$];
  obs_t         obs_q[$];
  logic         probe = 1'b0;
  logic [127:0] m_ctrl;
  int           total = 0;
  int           bad = 0;

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (spi_ack) begin
        total++;
        if (ack_q.size() == 0) begin
          bad++;
          $display("FAIL extra_ack got=1 want=0");
        end else begin
          ack_t e;
          e = ack_q.pop_front();
          $display("ack  ctrl_wr=%02h", ctrl_wr);
          if (ctrl_wr !== e.cw) begin
            bad++;
            $display("FAIL ack_ctrl_wr got=%02h want=%02h", ctrl_wr, e.cw);
          end
          total++;
          if (ctrl_regs !== e.regs) begin
            bad++;
            $display("FAIL ack_ctrl_regs got=%032h want=%032h", ctrl_regs, e.regs);
          end
        end
      end
      if (probe) begin
        total++;
        if (obs_q.size() == 0) begin
          bad++;
          $display("FAIL probe_underflow got=0 want=1");
        end else begin
          obs_t         o;
          logic [127:0] act;
          o = obs_q.pop_front();
          case (o.sel)
            0:       act = {112'd0, reg_dout};
            1:       act = {127'd0, irq};
            2:       act = {127'd0, spi_ack};
            3:       act = {120'd0, ctrl_wr};
            default: act = ctrl_regs;
          endcase
          $display("chk  %s got=%0h", o.name, act);
          if (act !== o.val) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", o.name, act, o.val);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_obs(input string name, input int sel, input logic [127:0] val);
    obs_t o;
    o.name = name;
    o.sel  = sel;
    o.val  = val;
    obs_q.push_back(o);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic push_ack(input logic [6:0] a, input logic [15:0] d);
    ack_t e;
    if (a < 7'd8) begin
      m_ctrl[int'(a)*16 +: 16] = d;
      e.cw = 8'(1 << a);
    end else begin
      e.cw = 8'h00;
    end
    e.regs = m_ctrl;
    ack_q.push_back(e);
  endtask

  // Full handshake: commit at the first edge, ack checked in the following cycle.
  task automatic wr(input logic [6:0] a, input logic [15:0] d, input logic [15:0] s);
    push_ack(a, d);
    spi_req  = 1'b1;
    spi_addr = a;
    reg_din  = d;
    irq_set  = s;
    tick();
    irq_set = 16'h0000;
    expect_obs("ack_latency", 2, 128'd1);
    spi_req = 1'b0;
    tick();
  endtask

  task automatic rd(input string name, input logic [6:0] a, input logic [15:0] e);
    spi_addr = a;
    tick();
    expect_obs(name, 0, {112'd0, e});
  endtask

  // ---------------- directed tests ----------------
  initial begin
    m_ctrl = {8{CTRL_RST}};
    for (int k = 0; k < 16; k++) begin
      sts_in[16*k +: 16] = {4'hC, 4'(k), 8'h5A};
    end

    // T1 reset
    rst = 1'b1;
    spi_addr = 7'h0F;
    tick(); tick(); tick();
    expect_obs("rst_ack", 2, 128'd0);
    expect_obs("rst_ctrl_wr", 3, 128'd0);
    expect_obs("rst_irq", 1, 128'd0);
    expect_obs("rst_dout", 0, 128'd0);
    expect_obs("rst_ctrl_regs", 4, {8{CTRL_RST}});
    rst = 1'b0;
    rd("rd_id", 7'h0F, 16'h5A01);

    // T2 control write
    wr(7'h03, 16'hBEEF, 16'h0000);
    rd("rd_ctrl3", 7'h03, 16'hBEEF);

    // T3 held request: one commit only, din changes while held are ignored
    push_ack(7'h0A, 16'h1111);
    spi_req  = 1'b1;
    spi_addr = 7'h0A;
    reg_din  = 16'h1111;
    tick();
    reg_din = 16'h2222;
    repeat (9) tick();
    spi_req = 1'b0;
    tick(); tick();
    rd("rd_scratch_held", 7'h0A, 16'h1111);
    wr(7'h0A, 16'h3333, 16'h0000);
    rd("rd_scratch_new", 7'h0A, 16'h3333);

    // T4 read-only and unmapped writes
    wr(7'h0F, 16'h1234, 16'h0000);
    rd("rd_id_ro", 7'h0F, 16'h5A01);
    wr(7'h15, 16'h1234, 16'h0000);
    rd("rd_sts5", 7'h15, 16'hC55A);
    rd("rd_sts15", 7'h1F, 16'hCF5A);
    wr(7'h40, 16'h1234, 16'h0000);
    rd("rd_unmapped", 7'h40, 16'h0000);

    // T5 interrupts
    wr(7'h09, 16'h0001, 16'h0000);
    rd("rd_mask", 7'h09, 16'h0001);
    irq_set = 16'h0001;
    tick();
    irq_set = 16'h0000;
    expect_obs("irq_lag", 1, 128'd0);
    expect_obs("irq_on", 1, 128'd1);
    rd("rd_stat_set", 7'h08, 16'h0001);
    wr(7'h08, 16'h0001, 16'h0001);
    rd("rd_stat_setwins", 7'h08, 16'h0001);
    expect_obs("irq_still_on", 1, 128'd1);
    wr(7'h08, 16'h0001, 16'h0000);
    rd("rd_stat_clr", 7'h08, 16'h0000);
    expect_obs("irq_off", 1, 128'd0);
    irq_set = 16'h0002;
    tick();
    irq_set = 16'h0000;
    tick();
    expect_obs("irq_masked", 1, 128'd0);
    rd("rd_stat_b1", 7'h08, 16'h0002);

    // T6 reset during the ACK cycle, request still high afterwards
    push_ack(7'h01, 16'h00AA);
    spi_req  = 1'b1;
    spi_addr = 7'h01;
    reg_din  = 16'h00AA;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ctrl = {8{CTRL_RST}};
    push_ack(7'h01, 16'h00AA);
    expect_obs("ack_after_rst", 2, 128'd0);
    tick();
    spi_req = 1'b0;
    tick(); tick();
    rd("rd_ctrl1_rerun", 7'h01, 16'h00AA);
    rd("rd_ctrl3_rst", 7'h03, CTRL_RST);
    rd("rd_scratch_rst", 7'h0A, 16'h0000);
    rd("rd_stat_rst", 7'h08, 16'h0000);

    repeat (3) tick();
    total++;
    if (ack_q.size() != 0) begin
      bad++;
      $display("FAIL missing_acks got=%0d want=0", ack_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
